// File: rtl/npu_pipe_pkg.sv
// Shared helpers for the NPU pipeline output-side blocks.
//
// Contents:
//   clog2_min1 - address/pointer width helper that never returns zero, so a
//                two-entry (or degenerate one-entry) array still gets a
//                1-bit index.
package npu_pipe_pkg;

  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// Storage array behind the pipe_out_fifo head register.
//
// Ports:
//   clk      - clock, write happens on the rising edge
//   wr_en    - write strobe
//   wr_addr  - write index
//   wr_data  - write payload
//   rd_addr  - read index
//   rd_data  - combinational read of entry rd_addr
//
// The data array is deliberately not reset: the controller only ever reads
// entries it has written, so reset would only cost flops.
module pipe_fifo_mem
  import npu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read so the controller can refill the head in the same
  // cycle it pops.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_out_fifo.sv
// Elastic output buffer sitting directly after a pipe_ctrl pipeline.
//
// Ports:
//   i_clk          - clock, all state on the rising edge
//   i_reset        - asynchronous active-low reset
//   i_input_valid  - producer (pipe_ctrl o_output_valid) has data
//   o_input_ready  - buffer can accept; registered, feeds pipe_ctrl
//   i_input_data   - payload sampled on push
//   o_output_valid - head entry valid; registered
//   i_output_ready - consumer accepts the head this cycle
//   o_output_data  - head payload; registered, held while stalled
//   o_count        - entries held, including the head register
//   o_almost_full  - o_count >= DEPTH - AF_MARGIN; registered
//
// The head register holds the oldest entry; the array holds the rest, so
// the array never carries more than DEPTH-1 items. Ready is computed from
// the next count only, which keeps the consumer's ready out of the
// producer's timing path at the cost of one bubble when leaving full.
module pipe_out_fifo
  import npu_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int AF_MARGIN = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_input_valid,
  output logic                       o_input_ready,
  input  logic [DATA_W-1:0]          i_input_data,
  output logic                       o_output_valid,
  input  logic                       i_output_ready,
  output logic [DATA_W-1:0]          o_output_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  stored;
  logic              input_ready_q;
  logic              output_valid_q;
  logic              almost_full_q;
  logic [DATA_W-1:0] output_data_q;
  logic [DATA_W-1:0] mem_rd_data;

  logic push;
  logic pop;
  logic head_from_mem;
  logic head_from_input;
  logic mem_wr_en;

  // Handshake decode and routing of the incoming word. A push lands in the
  // head register when the head is empty, or when the head is being popped
  // and nothing is waiting in the array; otherwise it goes to the array.
  // Whenever the array holds something, a pop refills the head from it.
  always_comb begin
    push            = i_input_valid & input_ready_q;
    pop             = output_valid_q & i_output_ready;
    stored          = count_q - CNT_W'(output_valid_q);
    head_from_mem   = pop & (stored != '0);
    head_from_input = push & (~output_valid_q | (pop & (stored == '0)));
    mem_wr_en       = push & ~head_from_input;
    count_next      = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  pipe_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (i_clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (i_input_data),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  // Count, flags and pointers. Ready and almost-full are registered from
  // the next count; ready stays low through reset and rises on the first
  // edge after release. Pointers wrap modulo DEPTH by overflow.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_q       <= '0;
      input_ready_q <= 1'b0;
      almost_full_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      count_q       <= count_next;
      input_ready_q <= (count_next < FULL_LEVEL);
      almost_full_q <= (count_next >= AF_LEVEL);
      if (mem_wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (head_from_mem) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Head register. Data changes only when a new entry is loaded, so the
  // payload is stable for as long as the consumer stalls.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      output_valid_q <= 1'b0;
      output_data_q  <= '0;
    end else if (head_from_mem) begin
      output_valid_q <= 1'b1;
      output_data_q  <= mem_rd_data;
    end else if (head_from_input) begin
      output_valid_q <= 1'b1;
      output_data_q  <= i_input_data;
    end else if (pop) begin
      output_valid_q <= 1'b0;
    end
  end

  assign o_input_ready  = input_ready_q;
  assign o_output_valid = output_valid_q;
  assign o_output_data  = output_data_q;
  assign o_count        = count_q;
  assign o_almost_full  = almost_full_q;

endmodule
